// File: rtl/ifu_axi_prefetch.sv
// ifu_axi_prefetch: instruction fetch unit, AXI4 read-only burst master.
// Bursts are fetched into a registered prefetch FIFO which feeds IDU over a
// valid/ready handshake. Redirect flushes the FIFO and restarts fetch.
// Optional build macro IFU_PERF_CNT_EN adds saturating fetch/stall counters.
module ifu_axi_prefetch #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 64,
  parameter int unsigned        INST_W     = 32,
  parameter int unsigned        BURST_LEN  = 4,
  parameter int unsigned        FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC   = 32'h8000_0000,
  parameter logic [3:0]         AXI_ID     = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
`endif
);

  localparam int unsigned SLOTS   = DATA_W / INST_W;
  localparam int unsigned IBYTES  = INST_W / 8;
  localparam int unsigned BEAT_B  = DATA_W / 8;
  localparam int unsigned BBYTES  = BURST_LEN * BEAT_B;
  // Burst window: never cross a BBYTES block nor a 4KB page.
  localparam int unsigned BOUND   = (BBYTES < 4096) ? BBYTES : 4096;
  localparam int unsigned BEAT_SH = $clog2(BEAT_B);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned SW      = $clog2(SLOTS + 1);

  localparam logic [ADDR_W-1:0] BEAT_LOW  = ADDR_W'(BEAT_B - 1);
  localparam logic [ADDR_W-1:0] BOUND_LOW = ADDR_W'(BOUND - 1);
  localparam logic [ADDR_W-1:0] BOUND_A   = ADDR_W'(BOUND);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [ADDR_W-1:0] r_beat_addr;
  logic              r_drop;
  logic              r_pend_drop;
  logic              r_fault_seen;

  logic [INST_W-1:0] r_mem_inst  [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_pc    [FIFO_DEPTH];
  logic              r_mem_fault [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;

  logic [PW-1:0]     w_count;
  logic [31:0]       w_free;
  logic [31:0]       w_need;
  logic [ADDR_W-1:0] w_pc_src;
  logic [ADDR_W-1:0] w_req_addr;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_beats;
  logic [7:0]        w_req_len;
  logic              w_ar_load;
  logic              w_ar_hs;
  logic              w_beat;
  logic              w_beat_fault;
  logic              w_pop;
  logic              w_push_en;
  logic [PW-1:0]     w_push_cnt;
  logic [ADDR_W-1:0] w_slot_pc [SLOTS];
  logic              w_keep    [SLOTS];
  logic [AW-1:0]     w_wr_idx  [SLOTS];
  logic [SW-1:0]     w_skip;
  logic [ADDR_W-1:0] w_burst_end;
  logic              w_unused_rid;

  assign w_unused_rid = ^rid;

  // Burst request derived from the current (or incoming redirect) fetch PC.
  assign w_pc_src   = redirect_valid ? redirect_pc : r_fetch_pc;
  assign w_req_addr = w_pc_src & ~BEAT_LOW;
  assign w_off      = w_req_addr & BOUND_LOW;
  assign w_beats    = (BOUND_A - w_off) >> BEAT_SH;
  assign w_req_len  = 8'(w_beats - ADDR_W'(1));
  assign w_need     = 32'(w_beats) * 32'(SLOTS);

  assign w_count    = r_wptr - r_rptr;
  assign w_free     = 32'(FIFO_DEPTH) - 32'(w_count);

  assign w_ar_hs      = (r_state == S_AR) && arready;
  assign w_beat       = (r_state == S_R) && rvalid;
  assign w_beat_fault = (rresp != 2'b00);
  assign w_pop        = inst_valid && inst_ready && !redirect_valid;
  assign w_push_en    = w_beat && !r_drop && !redirect_valid;
  assign w_push_cnt   = PW'(SLOTS) - PW'(w_skip);
  assign w_burst_end  = r_araddr + ((ADDR_W'(r_arlen) + ADDR_W'(1)) << BEAT_SH);

  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arid    = AXI_ID;
  assign arsize  = 3'(BEAT_SH);
  assign arburst = 2'b01;

  assign inst_valid = (r_wptr != r_rptr);
  assign inst       = r_mem_inst[r_rptr[AW-1:0]];
  assign inst_pc    = r_mem_pc[r_rptr[AW-1:0]];
  assign inst_fault = r_mem_fault[r_rptr[AW-1:0]];

  // Slot filtering: only low slots of the first beat can precede fetch_pc,
  // so kept slots are a contiguous upper run packed from the write pointer.
  always_comb begin
    w_skip = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      w_slot_pc[s] = r_beat_addr + ADDR_W'(s * IBYTES);
      w_keep[s]    = (w_slot_pc[s] >= r_fetch_pc);
      if (!w_keep[s]) w_skip = w_skip + 1'b1;
    end
  end

  // FIFO write index for each beat slot after removing skipped low slots.
  always_comb begin
    for (int unsigned s = 0; s < SLOTS; s++) begin
      w_wr_idx[s] = r_wptr[AW-1:0] + AW'(s) - AW'(w_skip);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and AXI handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ar_load   = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A redirect empties the FIFO, so a full burst always fits.
        if (redirect_valid || (w_free >= w_need)) begin
          w_state_nxt = S_AR;
          w_ar_load   = 1'b1;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) w_state_nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          if (r_drop || redirect_valid)             w_state_nxt = S_IDLE;
          else if (r_fault_seen || w_beat_fault)    w_state_nxt = S_HALT;
          else                                      w_state_nxt = S_IDLE;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          w_state_nxt = S_AR;
          w_ar_load   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC, burst request registers, beat tracking and drop control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_beat_addr  <= '0;
      r_drop       <= 1'b0;
      r_pend_drop  <= 1'b0;
      r_fault_seen <= 1'b0;
    end else begin
      if (w_ar_load) begin
        r_araddr <= w_req_addr;
        r_arlen  <= w_req_len;
      end

      if (redirect_valid)                r_fetch_pc <= redirect_pc;
      else if (w_beat && rlast && !r_drop) r_fetch_pc <= w_burst_end;

      // A redirect while AR is pending cannot retract arvalid; remember it
      // and turn the accepted burst into a drop burst.
      if (w_ar_hs) begin
        r_beat_addr  <= r_araddr;
        r_fault_seen <= 1'b0;
        r_drop       <= r_pend_drop | redirect_valid;
        r_pend_drop  <= 1'b0;
      end else if ((r_state == S_AR) && redirect_valid) begin
        r_pend_drop  <= 1'b1;
      end

      if (w_beat) begin
        r_beat_addr <= r_beat_addr + ADDR_W'(BEAT_B);
        if (w_beat_fault) r_fault_seen <= 1'b1;
        if (rlast)               r_drop <= 1'b0;
        else if (redirect_valid) r_drop <= 1'b1;
      end else if ((r_state == S_R) && redirect_valid) begin
        r_drop <= 1'b1;
      end
    end
  end

  // FIFO pointers: redirect clears, otherwise independent push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (redirect_valid) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      if (w_push_en) r_wptr <= r_wptr + w_push_cnt;
    end
  end

  // FIFO storage: each accepted beat writes its kept slots, low slot first.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      for (int unsigned s = 0; s < SLOTS; s++) begin
        if (w_keep[s]) begin
          r_mem_inst[w_wr_idx[s]]  <= rdata[s*INST_W +: INST_W];
          r_mem_pc[w_wr_idx[s]]    <= w_slot_pc[s];
          r_mem_fault[w_wr_idx[s]] <= w_beat_fault;
        end
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [63:0] r_perf_fetch;
  logic [63:0] r_perf_stall;

  // Saturating counters: instructions delivered and IDU starvation cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop && (r_perf_fetch != '1))                   r_perf_fetch <= r_perf_fetch + 64'd1;
      if (inst_ready && !inst_valid && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 64'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifu_axi_prefetch.sv
// Directed bench for ifu_axi_prefetch: the bench acts as AXI slave and IDU.
// Memory model: the 32-bit word at address a holds a >> 2.
`timescale 1ns/1ps
module tb_ifu_axi_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  int          ar_cnt = 0;
  logic [31:0] ar_last_addr = '0;
  logic [7:0]  ar_last_len  = '0;
  logic [31:0] pq_pc[$];
  logic [31:0] pq_inst[$];
  logic        pq_flt[$];

  ifu_axi_prefetch #(
    .ADDR_W(32), .DATA_W(64), .INST_W(32), .BURST_LEN(4),
    .FIFO_DEPTH(8), .RESET_PC(32'h8000_0000), .AXI_ID(4'd0)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  // IDU side: record every accepted instruction.
  always @(posedge clk) begin
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      pq_pc.push_back(inst_pc);
      pq_inst.push_back(inst);
      pq_flt.push_back(inst_fault);
    end
  end

  // AR side: record every accepted address request.
  always @(posedge clk) begin
    if (!rst && arvalid && arready) begin
      ar_cnt++;
      ar_last_addr = araddr;
      ar_last_len  = arlen;
    end
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pops();
    pq_pc.delete();
    pq_inst.delete();
    pq_flt.delete();
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [1:0] resp, input logic last,
                           input logic redir, input logic [31:0] rpc);
    rvalid = 1'b1;
    rdata  = {word(a + 32'd4), word(a)};
    rresp  = resp;
    rlast  = last;
    redirect_valid = redir;
    redirect_pc    = rpc;
    chk("rready_in_burst", rready, 1);
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    redirect_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      send_beat(a + 32'(i * 8), 2'b00, (i == 3), 1'b0, 32'h0);
  endtask

  task automatic wait_ar(input int n, input string tag);
    int k = 0;
    while (ar_cnt < n && k < 40) begin
      tick();
      k++;
    end
    chk(tag, (ar_cnt >= n), 1);
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k = 0;
    while (pq_pc.size() < n && k < 40) begin
      tick();
      k++;
    end
    chk(tag, (pq_pc.size() >= n), 1);
  endtask

  task automatic check_pops(input logic [31:0] base, input int n, input logic [7:0] fmask);
    for (int i = 0; i < n; i++) begin
      if (i < pq_pc.size()) begin
        chk("pop_pc",    pq_pc[i],   base + 32'(i * 4));
        chk("pop_inst",  pq_inst[i], word(base + 32'(i * 4)));
        chk("pop_fault", pq_flt[i],  fmask[i]);
      end else begin
        chk("pop_missing", 0, 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    rst = 1'b0;

    // First AR one cycle after reset release
    tick();
    chk("ar0_valid", arvalid, 1);
    chk("ar0_addr", araddr, 32'h8000_0000);
    chk("ar0_len", arlen, 3);
    chk("ar0_size", arsize, 3);
    chk("ar0_burst", arburst, 1);
    chk("ar0_id", arid, 0);
    tick();
    chk("ar0_cnt", ar_cnt, 1);
    chk("r0_rready", rready, 1);
    chk("r0_arvalid", arvalid, 0);

    // First burst with IDU stalled; head visible one cycle after beat
    send_beat(32'h8000_0000, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("lat_valid", inst_valid, 1);
    chk("lat_pc", inst_pc, 32'h8000_0000);
    chk("lat_inst", inst, 32'h2000_0000);
    chk("lat_fault", inst_fault, 0);
    for (int i = 1; i < 4; i++)
      send_beat(32'h8000_0000 + 32'(i * 8), 2'b00, (i == 3), 1'b0, 32'h0);

    // Full FIFO: no new AR, still none after one pop
    repeat (3) tick();
    chk("full_no_ar", ar_cnt, 1);
    chk("full_arvalid", arvalid, 0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("one_pop", pq_pc.size(), 1);
    repeat (3) tick();
    chk("one_pop_no_ar", ar_cnt, 1);

    // Drain the rest; next sequential AR follows
    inst_ready = 1'b1;
    wait_pops(8, "drain8_timeout");
    wait_ar(2, "ar1_timeout");
    chk("ar1_addr", ar_last_addr, 32'h8000_0020);
    chk("ar1_len", ar_last_len, 3);
    check_pops(32'h8000_0000, 8, 8'h00);

    inst_ready = 1'b0;
    send_burst(32'h8000_0020);
    chk("b1_head_pc", inst_pc, 32'h8000_0020);

    // Redirect from IDLE to a mid-block PC
    clear_pops();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0014;
    tick();
    redirect_valid = 1'b0;
    chk("rdi_flush", inst_valid, 0);
    chk("rdi_arvalid", arvalid, 1);
    chk("rdi_addr", araddr, 32'h8000_0010);
    chk("rdi_len", arlen, 1);
    wait_ar(3, "rdi_ar_timeout");
    send_beat(32'h8000_0010, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("rdi_head_valid", inst_valid, 1);
    chk("rdi_head_pc", inst_pc, 32'h8000_0014);
    chk("rdi_head_inst", inst, 32'h2000_0005);
    inst_ready = 1'b1;
    send_beat(32'h8000_0018, 2'b00, 1'b1, 1'b0, 32'h0);
    wait_pops(3, "rdi_pops_timeout");
    chk("rdi_pop_count", pq_pc.size(), 3);
    check_pops(32'h8000_0014, 3, 8'h00);
    wait_ar(4, "ar_after_rdi_timeout");
    chk("ar_after_rdi_addr", ar_last_addr, 32'h8000_0020);
    chk("ar_after_rdi_len", ar_last_len, 3);

    // Redirect mid-burst after beat 1
    clear_pops();
    send_beat(32'h8000_0020, 2'b00, 1'b0, 1'b0, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("mid_flush", inst_valid, 0);
    chk("mid_no_pop", pq_pc.size(), 0);
    for (int i = 1; i < 4; i++) begin
      send_beat(32'h8000_0020 + 32'(i * 8), 2'b00, (i == 3), 1'b0, 32'h0);
      chk("mid_drop_valid", inst_valid, 0);
    end
    wait_ar(5, "mid_ar_timeout");
    chk("mid_ar_addr", ar_last_addr, 32'h8000_0100);
    chk("mid_ar_len", ar_last_len, 3);
    chk("mid_no_stale", pq_pc.size(), 0);

    // Bus error on beat 2 -> faulted entries, then halt
    send_beat(32'h8000_0100, 2'b00, 1'b0, 1'b0, 32'h0);
    send_beat(32'h8000_0108, 2'b10, 1'b0, 1'b0, 32'h0);
    send_beat(32'h8000_0110, 2'b00, 1'b0, 1'b0, 32'h0);
    send_beat(32'h8000_0118, 2'b00, 1'b1, 1'b0, 32'h0);
    wait_pops(8, "flt_pops_timeout");
    check_pops(32'h8000_0100, 8, 8'b0000_1100);
    repeat (12) tick();
    chk("halt_no_ar", ar_cnt, 5);
    chk("halt_arvalid", arvalid, 0);
    chk("halt_empty", inst_valid, 0);

    // Redirect out of halt
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("unhalt_arvalid", arvalid, 1);
    chk("unhalt_addr", araddr, 32'h8000_0200);
    chk("unhalt_len", arlen, 3);
    wait_ar(6, "unhalt_ar_timeout");

    // Redirect coincident with a pop and an R beat
    clear_pops();
    send_beat(32'h8000_0200, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("coin_pre_valid", inst_valid, 1);
    send_beat(32'h8000_0208, 2'b00, 1'b0, 1'b1, 32'h8000_0300);
    chk("coin_flush", inst_valid, 0);
    chk("coin_no_pop", pq_pc.size(), 0);
    send_beat(32'h8000_0210, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("coin_drop_valid", inst_valid, 0);
    send_beat(32'h8000_0218, 2'b00, 1'b1, 1'b0, 32'h0);
    chk("coin_drop_last", inst_valid, 0);
    wait_ar(7, "coin_ar_timeout");
    chk("coin_ar_addr", ar_last_addr, 32'h8000_0300);
    chk("coin_ar_len", ar_last_len, 3);
    send_burst(32'h8000_0300);
    wait_pops(8, "resume_pops_timeout");
    chk("resume_pop_count", pq_pc.size(), 8);
    check_pops(32'h8000_0300, 8, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
